// File: rtl/data_ram_pkg.sv
// Shared state encoding, fill-pattern selectors and the power-on fill function
// used by the data RAM controller.
package data_ram_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } ram_state_e;

  localparam int INIT_ZERO   = 0;
  localparam int INIT_DOUBLE = 1;

  // Wide result; callers truncate to their own word width.
  function automatic logic [31:0] init_pattern(input int unsigned index, input int mode);
    if (mode == INIT_DOUBLE) begin
      return 32'(index * 2);
    end
    return '0;
  endfunction

endpackage

// File: rtl/ram_array.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module ram_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_ram_ctrl.sv
// Data-memory controller: post-reset fill sweep, request acceptance with optional
// wait states, one-cycle read response on the shared bus, and rejection flagging.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int INIT_MODE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_to_ram,
  inout  wire  [DATA_WIDTH-1:0] data_ram,
  input  logic                  write_enable_to_ram,
  input  logic                  read_enable_to_ram,
  output logic                  ram_ready,
  output logic                  read_valid,
  output logic                  init_done,
  output logic                  access_err
);

  localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [3:0]            LastWait = 4'(WAIT_STATES - 1);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_write_q, is_write_d;
  logic                  init_done_q, init_done_d;
  logic                  access_err_q, access_err_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  any_en, accept, reject;

  assign any_en = write_enable_to_ram | read_enable_to_ram;
  assign accept = (state_q == IDLE) && (write_enable_to_ram ^ read_enable_to_ram)
                  && ({1'b0, address_to_ram} < DepthExt);
  assign reject = (state_q == IDLE) && any_en && !accept;

  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_write_d   = is_write_q;
    init_done_d  = init_done_q;
    access_err_d = reject;
    mem_we       = 1'b0;
    mem_waddr    = addr_q;
    mem_wdata    = wdata_q;
    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_ptr_q;
        mem_wdata  = DATA_WIDTH'(init_pattern(32'(init_ptr_q), INIT_MODE));
        init_ptr_d = init_ptr_q + ADDR_WIDTH'(1);
        if (init_ptr_q == LastIdx) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          init_ptr_d  = '0;
        end
      end
      IDLE: begin
        if (accept) begin
          addr_d     = address_to_ram;
          wdata_d    = data_ram;
          is_write_d = write_enable_to_ram;
          wait_cnt_d = '0;
          // Zero-wait writes commit straight from the bus so writes stream at one per cycle.
          if (WAIT_STATES == 0) begin
            if (write_enable_to_ram) begin
              mem_we    = 1'b1;
              mem_waddr = address_to_ram;
              mem_wdata = data_ram;
            end else begin
              state_d = RESP;
            end
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == LastWait) begin
          if (is_write_q) begin
            mem_we  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RESP;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= INIT;
      init_ptr_q   <= '0;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      init_done_q  <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      init_done_q  <= init_done_d;
      access_err_q <= access_err_d;
    end
  end

  // Gating with reset drops a write that would otherwise land on the reset edge.
  ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram_array (
    .clk    (clk),
    .we_i   (mem_we & reset),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(addr_q),
    .rdata_o(mem_rdata)
  );

  assign ram_ready  = (state_q == IDLE);
  assign read_valid = (state_q == RESP);
  assign init_done  = init_done_q;
  assign access_err = access_err_q;
  assign data_ram   = read_valid ? mem_rdata : 'z;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: a zero-wait 64-word instance and a two-wait
// 48-word instance, each driven with directed and random requests against a memory model.
module tb_data_ram_ctrl;

  typedef struct {
    bit          isRead;
    int          edgeNo;
    logic [15:0] data;
  } RespT;

  logic clk = 1'b0;
  int   edgeCnt = 0;
  int   testsRun = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edgeCnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gDut
    localparam int Depth = (g == 0) ? 64 : 48;
    localparam int Ws    = (g == 0) ? 0 : 2;

    logic        resetN  = 1'b0;
    logic [5:0]  addr    = '0;
    logic        wrEn    = 1'b0;
    logic        rdEn    = 1'b0;
    logic        drvEn   = 1'b0;
    logic [15:0] drvData = '0;
    wire  [15:0] bus;
    logic        ready, valid, initDone, err;

    logic [15:0] mem [64];
    RespT        sb[$];
    int          resetEdge = 0;
    int          busyUntil = 0;
    bit          done = 1'b0;

    assign bus = drvEn ? drvData : 'z;

    data_ram_ctrl #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (6),
      .DEPTH      (Depth),
      .WAIT_STATES(Ws),
      .INIT_MODE  (1)
    ) dut (
      .clk                (clk),
      .reset              (resetN),
      .address_to_ram     (addr),
      .data_ram           (bus),
      .write_enable_to_ram(wrEn),
      .read_enable_to_ram (rdEn),
      .ram_ready          (ready),
      .read_valid         (valid),
      .init_done          (initDone),
      .access_err         (err)
    );

    // Model view of the cycle following edge edgeCnt.
    function automatic bit modelInitDone();
      return (edgeCnt - resetEdge) >= Depth;
    endfunction

    function automatic bit modelReady();
      return modelInitDone() && (edgeCnt >= busyUntil);
    endfunction

    // Called just after a falling edge; the inputs are sampled on edge edgeCnt+1.
    task automatic applyStimulus(input bit doRst, input bit w, input bit r,
                                 input logic [5:0] a, input logic [15:0] d);
      int e;
      bit rdy;
      e = edgeCnt + 1;
      rdy = modelReady();
      resetN  = !doRst;
      wrEn    = w;
      rdEn    = r;
      addr    = a;
      drvData = d;
      drvEn   = w && rdy && !doRst;
      if (doRst) begin
        resetEdge = e;
        busyUntil = 0;
        sb.delete();
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 2);
      end else if (rdy && (w || r)) begin
        if ((w && r) || (int'(a) >= Depth)) begin
          sb.push_back('{isRead: 1'b0, edgeNo: e, data: 16'h0});
        end else if (w) begin
          mem[a] = d;
          busyUntil = e + Ws;
        end else begin
          sb.push_back('{isRead: 1'b1, edgeNo: e + Ws, data: mem[a]});
          busyUntil = e + Ws + 1;
        end
      end
    endtask

    task automatic idleCycles(input int n);
      repeat (n) begin
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      end
    endtask

    task automatic resetCycles(input int n);
      repeat (n) begin
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      end
    endtask

    task automatic request(input bit w, input bit r, input logic [5:0] a, input logic [15:0] d);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!modelReady() && guard < 80) begin
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        guard++;
      end
      applyStimulus(1'b0, w, r, a, d);
    endtask

    initial begin
      int op;
      resetCycles(3);
      // Requests during the fill sweep must be ignored silently.
      repeat (Depth + 2) begin
        @(negedge clk);
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), 6'($urandom), 16'($urandom));
      end
      if (g == 0) begin
        request(1'b0, 1'b1, 6'd5, '0);
        request(1'b0, 1'b1, 6'd63, '0);
        request(1'b1, 1'b0, 6'd63, 16'h1234);
        request(1'b0, 1'b1, 6'd63, '0);
        request(1'b1, 1'b0, 6'd7, 16'hA5A5);
        request(1'b1, 1'b0, 6'd8, 16'h5A5A);
        request(1'b0, 1'b1, 6'd7, '0);
        request(1'b0, 1'b1, 6'd8, '0);
      end else begin
        request(1'b0, 1'b1, 6'd3, '0);
        request(1'b1, 1'b1, 6'd4, 16'hFFFF);
        request(1'b0, 1'b1, 6'd4, '0);
        request(1'b0, 1'b1, 6'd50, '0);
        request(1'b1, 1'b0, 6'd10, 16'hBEEF);
        idleCycles(1);
        resetCycles(2);
        idleCycles(Depth + 1);
        request(1'b0, 1'b1, 6'd10, '0);
      end
      for (int i = 0; i < 400; i++) begin
        op = $urandom_range(0, 99);
        @(negedge clk);
        if (op == 0) begin
          applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        end else begin
          applyStimulus(1'b0, (op < 45) || (op >= 90 && op < 95),
                        (op >= 45 && op < 95), 6'($urandom_range(0, 63)), 16'($urandom));
        end
      end
      idleCycles(Ws + 4);
      done = 1'b1;
    end

    initial forever begin
      bit          expValid;
      bit          expErr;
      logic [15:0] expData;
      @(posedge clk);
      #1;
      expValid = 1'b0;
      expErr   = 1'b0;
      expData  = '0;
      if (sb.size() > 0 && sb[0].edgeNo == edgeCnt) begin
        if (sb[0].isRead) begin
          expValid = 1'b1;
          expData  = sb[0].data;
        end else begin
          expErr = 1'b1;
        end
        void'(sb.pop_front());
      end
      checkOutput($sformatf("dut%0d ram_ready", g), 32'(ready), 32'(modelReady()));
      checkOutput($sformatf("dut%0d init_done", g), 32'(initDone), 32'(modelInitDone()));
      checkOutput($sformatf("dut%0d read_valid", g), 32'(valid), 32'(expValid));
      checkOutput($sformatf("dut%0d access_err", g), 32'(err), 32'(expErr));
      if (expValid) begin
        checkOutput($sformatf("dut%0d read_data", g), 32'(bus), 32'(expData));
      end
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(gDut[0].done && gDut[1].done) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("bench completion", 32'(gDut[0].done && gDut[1].done), 32'd1);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
